// File: rtl/count_sequencer_pkg.sv
// Shared encodings for the count sequencer: command opcodes and FSM states.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/count_sequencer.sv
// Command sequencer driving a downstream up/down counter: LOAD, UP/DOWN N steps
// with optional early stop on terminal count, and NOP.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              stop_on_tc,
  output logic [DATA_W-1:0] cnt_data,
  output logic              cnt_load,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  input  logic              cnt_terminal,
  output logic              busy,
  output logic              done,
  output logic              tc_stop
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] steps;
  logic              ready_q;
  logic              accept;
  logic              tc_hit;
  op_t               op_in;

  assign op_in  = op_t'(cmd_op);
  assign accept = cmd_valid && ready_q;
  assign tc_hit = stop_on_tc && cnt_terminal;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_in)
            OP_LOAD:        state_nxt = ST_LOAD;
            OP_UP, OP_DOWN: state_nxt = (cmd_arg == '0) ? ST_DONE : ST_RUN;
            default:        state_nxt = ST_DONE;
          endcase
        end
      end
      ST_LOAD: state_nxt = ST_DONE;
      ST_RUN: begin
        if (tc_hit || steps <= DATA_W'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low while reset is held
  // and for the first cycle after release, without a combinational path from reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      steps       <= '0;
      cnt_data    <= '0;
      cnt_up_down <= 1'b1;
      tc_stop     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      if (accept) begin
        steps   <= cmd_arg;
        tc_stop <= 1'b0;
        if (op_in == OP_LOAD) cnt_data <= cmd_arg;
        if ((op_in == OP_UP || op_in == OP_DOWN) && cmd_arg != '0)
          cnt_up_down <= (op_in == OP_UP);
      end
      if (state == ST_RUN) begin
        if (steps != '0) steps <= steps - 1'b1;
        if (tc_hit) tc_stop <= 1'b1;
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign cnt_load   = (state == ST_LOAD);
  assign cnt_enable = (state == ST_LOAD) || (state == ST_RUN);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench: expected per-cycle output vectors are queued when a command is
// driven, then popped and compared one cycle at a time after each clock edge.
module tb_count_sequencer;
  import count_sequencer_pkg::*;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       stop_on_tc;
  logic [3:0] cnt_data;
  logic       cnt_load;
  logic       cnt_enable;
  logic       cnt_up_down;
  logic       cnt_terminal;
  logic       busy;
  logic       done;
  logic       tc_stop;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // {ready, busy, load, enable, up_down, data[3:0], done, tc_stop}
  logic [10:0] exp_q[$];
  string       tag_q[$];

  count_sequencer #(.DATA_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .stop_on_tc   (stop_on_tc),
    .cnt_data     (cnt_data),
    .cnt_load     (cnt_load),
    .cnt_enable   (cnt_enable),
    .cnt_up_down  (cnt_up_down),
    .cnt_terminal (cnt_terminal),
    .busy         (busy),
    .done         (done),
    .tc_stop      (tc_stop)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void push(string tag, logic rdy, logic bsy, logic ld, logic en,
                               logic ud, logic [3:0] data, logic dn, logic tc);
    exp_q.push_back({rdy, bsy, ld, en, ud, data, dn, tc});
    tag_q.push_back(tag);
  endfunction

  task automatic tick();
    logic [10:0] obs;
    logic [10:0] e;
    string       t;
    @(posedge clock);
    #1;
    checks++;
    obs = {cmd_ready, busy, cnt_load, cnt_enable, cnt_up_down, cnt_data, done, tc_stop};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: observed %b, required a queued expectation", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: rdy,busy,ld,en,ud,data,done,tc observed %b required %b", t, obs, e);
      end
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic send(input op_t op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    cmd_valid    = 1'b1;
    cmd_op       = OP_LOAD;
    cmd_arg      = 4'd9;
    stop_on_tc   = 1'b0;
    cnt_terminal = 1'b0;

    // Reset held with a command offered: nothing accepted, ready low
    push("reset_a", 0, 0, 0, 0, 1, 4'd0, 0, 0);
    push("reset_b", 0, 0, 0, 0, 1, 4'd0, 0, 0);
    ticks(2);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    push("idle_after_reset", 1, 0, 0, 0, 1, 4'd0, 0, 0);
    tick();

    // LOAD 5
    push("load_strobe", 0, 1, 1, 1, 1, 4'd5, 0, 0);
    push("load_done",   0, 1, 0, 0, 1, 4'd5, 1, 0);
    push("load_idle",   1, 0, 0, 0, 1, 4'd5, 0, 0);
    send(OP_LOAD, 4'd5);
    ticks(2);

    // UP 3, no early stop
    for (int unsigned i = 0; i < 3; i++) push("up3_run", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("up3_done", 0, 1, 0, 0, 1, 4'd5, 1, 0);
    push("up3_idle", 1, 0, 0, 0, 1, 4'd5, 0, 0);
    send(OP_UP, 4'd3);
    ticks(4);

    // DOWN 0: straight to DONE, direction unchanged
    push("down0_done", 0, 1, 0, 0, 1, 4'd5, 1, 0);
    push("down0_idle", 1, 0, 0, 0, 1, 4'd5, 0, 0);
    send(OP_DOWN, 4'd0);
    tick();

    // NOP with nonzero arg: arg ignored
    push("nop_done", 0, 1, 0, 0, 1, 4'd5, 1, 0);
    push("nop_idle", 1, 0, 0, 0, 1, 4'd5, 0, 0);
    send(OP_NOP, 4'd7);
    tick();

    // DOWN 2: direction flips and holds afterwards
    for (int unsigned i = 0; i < 2; i++) push("down2_run", 0, 1, 0, 1, 0, 4'd5, 0, 0);
    push("down2_done", 0, 1, 0, 0, 0, 4'd5, 1, 0);
    push("down2_idle", 1, 0, 0, 0, 0, 4'd5, 0, 0);
    send(OP_DOWN, 4'd2);
    ticks(3);

    // UP 15: maximum step count
    for (int unsigned i = 0; i < 15; i++) push("up15_run", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("up15_done", 0, 1, 0, 0, 1, 4'd5, 1, 0);
    push("up15_idle", 1, 0, 0, 0, 1, 4'd5, 0, 0);
    send(OP_UP, 4'd15);
    ticks(16);

    // UP 10 with early stop: terminal seen on the edge completing step 2
    stop_on_tc = 1'b1;
    push("early_run1", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("early_run2", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("early_done", 0, 1, 0, 0, 1, 4'd5, 1, 1);
    push("early_idle_tc_held", 1, 0, 0, 0, 1, 4'd5, 0, 1);
    send(OP_UP, 4'd10);
    tick();
    cnt_terminal = 1'b1;
    tick();
    cnt_terminal = 1'b0;
    tick();

    // UP 2: terminal on the same edge as the last step; tc_stop cleared by accept
    push("simul_run1", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("simul_run2", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("simul_done", 0, 1, 0, 0, 1, 4'd5, 1, 1);
    push("simul_idle", 1, 0, 0, 0, 1, 4'd5, 0, 1);
    push("simul_idle2", 1, 0, 0, 0, 1, 4'd5, 0, 1);
    send(OP_UP, 4'd2);
    tick();
    cnt_terminal = 1'b1;
    tick();
    cnt_terminal = 1'b0;
    ticks(2);
    stop_on_tc = 1'b0;

    // UP 8 aborted by reset after step 4, with a command offered during reset
    for (int unsigned i = 0; i < 4; i++) push("abort_run", 0, 1, 0, 1, 1, 4'd5, 0, 0);
    push("abort_reset", 0, 0, 0, 0, 1, 4'd0, 0, 0);
    push("abort_ready", 1, 0, 0, 0, 1, 4'd0, 0, 0);
    push("abort_no_done", 1, 0, 0, 0, 1, 4'd0, 0, 0);
    send(OP_UP, 4'd8);
    ticks(3);
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 4'd11;
    tick();
    reset     = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    ticks(2);

    // Valid held through busy with a changing arg
    push("hold_load7",  0, 1, 1, 1, 1, 4'd7, 0, 0);
    push("hold_done7",  0, 1, 0, 0, 1, 4'd7, 1, 0);
    push("hold_idle",   1, 0, 0, 0, 1, 4'd7, 0, 0);
    push("hold_load9",  0, 1, 1, 1, 1, 4'd9, 0, 0);
    push("hold_done9",  0, 1, 0, 0, 1, 4'd9, 1, 0);
    push("hold_idle9",  1, 0, 0, 0, 1, 4'd9, 0, 0);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 4'd7;
    tick();
    cmd_arg = 4'd3;
    tick();
    cmd_arg = 4'd12;
    tick();
    cmd_arg = 4'd9;
    tick();
    cmd_valid = 1'b0;
    ticks(2);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover expectations, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
